wait_arb: RTL and testbench

WAIT_ARB -- requirements
Module: wait_arb

---
 rtl/wait_arb_if.sv | 24 ++
 rtl/wait_arb.sv | 125 ++++++++++++
 tb/tb_wait_arb.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wait_arb_if.sv
// Bundle of requester-side and WAIT-timer-side signals for wait_arb.
// slave is the arbiter's view; master is the requesters/timer environment.
interface wait_arb_if #(
  parameter int DW = 8
);
  logic [3:0]      req;
  logic [4*DW-1:0] dur;
  logic [3:0]      grant;
  logic [3:0]      done;
  logic            busy;
  logic [DW-1:0]   wt_din;
  logic            wt_start;
  logic            wt_busy;

  modport master (
    output req, dur, wt_busy,
    input  grant, done, busy, wt_din, wt_start
  );

  modport slave (
    input  req, dur, wt_busy,
    output grant, done, busy, wt_din, wt_start
  );
endinterface

// File: rtl/wait_arb.sv
// Round-robin arbiter handing a single shared WAIT timer to one of four requesters.
// Includes a lost-start watchdog when the timer never reports busy.
module wait_arb #(
  parameter int DW = 8
) (
  input logic       clk,
  input logic       rst,
  wait_arb_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, ARM, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    grant_q, grant_d;
  logic [3:0]    done_q, done_d;
  logic          wt_start_q, wt_start_d;
  logic [DW-1:0] wt_din_q, wt_din_d;
  logic [1:0]    last_q, last_d;
  logic [1:0]    win_q, win_d;
  logic          arm_q, arm_d;

  logic [1:0]    pick;
  logic          pick_vld;
  logic [DW-1:0] pick_dur;

  // Search starts one past the previous owner and wraps modulo 4.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!pick_vld && bus.req[last_q + 2'(k + 1)]) begin
        pick     = last_q + 2'(k + 1);
        pick_vld = 1'b1;
      end
    end
    pick_dur = bus.dur[DW*pick +: DW];
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = '0;
    wt_start_d = 1'b0;
    wt_din_d   = wt_din_q;
    last_d     = last_q;
    win_d      = win_q;
    arm_d      = arm_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_vld) begin
          grant_d    = 4'(1) << pick;
          win_d      = pick;
          wt_din_d   = pick_dur;
          // Start pulse is registered so it coincides with the ISSUE cycle.
          wt_start_d = (pick_dur != '0);
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        arm_d = 1'b0;
        if (wt_din_q != '0) begin
          state_d = ARM;
        end else begin
          state_d = DONE;
          done_d  = 4'(1) << win_q;
        end
      end
      ARM: begin
        if (bus.wt_busy) begin
          state_d = RUN;
        end else if (arm_q) begin
          state_d = DONE;
          done_d  = 4'(1) << win_q;
        end else begin
          arm_d = 1'b1;
        end
      end
      RUN: begin
        if (!bus.wt_busy) begin
          state_d = DONE;
          done_d  = 4'(1) << win_q;
        end
      end
      DONE: begin
        last_d  = win_q;
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      wt_start_q <= 1'b0;
      wt_din_q   <= '0;
      last_q     <= 2'd3;
      win_q      <= '0;
      arm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      wt_start_q <= wt_start_d;
      wt_din_q   <= wt_din_d;
      last_q     <= last_d;
      win_q      <= win_d;
      arm_q      <= arm_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.wt_start = wt_start_q;
  assign bus.wt_din   = wt_din_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_wait_arb.sv
// Self-checking bench for wait_arb: reset vectors, directed corner sequences,
// and a randomized run against a transaction-level round-robin model.
module tb_wait_arb;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wait_arb_if #(.DW(DW)) bus ();
  wait_arb #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [3:0]      man_req = '0;
  logic [4*DW-1:0] man_dur = '0;
  logic [3:0]      rnd_req = '0;
  logic [4*DW-1:0] rnd_dur = '0;
  bit              rnd_on = 1'b0;
  assign bus.req = rnd_on ? rnd_req : man_req;
  assign bus.dur = rnd_on ? rnd_dur : man_dur;

  // WAIT timer: busy for exactly wt_din cycles after a start pulse.
  logic [DW-1:0] tcnt;
  bit tmr_dead = 1'b0;
  bit tmr_stuck = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst) tcnt <= '0;
    else if (bus.wt_start && !tmr_dead) tcnt <= bus.wt_din;
    else if (tcnt != '0) tcnt <= tcnt - 1'b1;
  end
  assign bus.wt_busy = (tcnt != '0) || tmr_stuck;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rr(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; man_req = '0; man_dur = '0; tmr_dead = 1'b0; tmr_stuck = 1'b0;
    @(negedge clk);
    chk("rst_grant", bus.grant, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_start", bus.wt_start, 0);
    chk("rst_din", bus.wt_din, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b1;
  endtask

  // Called on the ISSUE-cycle negedge (c=0); returns on the done negedge.
  task automatic watch(input int maxc, input int drop_at, output int starts,
                       output int done_at, output logic [3:0] done_v,
                       output int busy_last, output bit stable);
    logic [3:0] g0;
    g0 = bus.grant; starts = 0; done_at = -1; done_v = '0; busy_last = -1; stable = 1'b1;
    for (int c = 0; c < maxc; c++) begin
      if (c > 0) @(negedge clk);
      if (c == drop_at) begin man_req = '0; man_dur = '1; end
      if (bus.grant !== g0) stable = 1'b0;
      if (bus.wt_start) starts++;
      if (bus.wt_busy) busy_last = c;
      if (bus.done != '0) begin done_at = c; done_v = bus.done; break; end
    end
    chk("done_seen", (done_at >= 0), 1);
  endtask

  typedef struct {
    logic [3:0]      req;
    logic [4*DW-1:0] dur;
    logic [3:0]      g;
    logic [DW-1:0]   din;
    logic            st;
  } vec_t;
  vec_t tv [6];

  // Random-phase model state.
  logic [3:0]    m_g = '0, m_done = '0;
  logic [DW-1:0] m_din = '0;
  logic          m_st = 1'b0, m_busy = 1'b0;
  bit            m_act = 1'b0;
  int            m_k = 0, m_dn = 0, m_last = 3, m_w = 0, m_d = 0;

  always @(negedge clk) begin
    if (rnd_on) begin
      chk("rnd_grant", bus.grant, m_g);
      chk("rnd_done", bus.done, m_done);
      chk("rnd_start", bus.wt_start, m_st);
      chk("rnd_din", bus.wt_din, m_din);
      chk("rnd_busy", bus.busy, m_busy);
      for (int i = 0; i < 4; i++) begin
        if (bus.done[i]) rnd_req[i] = 1'b0;
        else if (rnd_req[i] && bus.grant[i] && $urandom_range(15) == 0) rnd_req[i] = 1'b0;
        else if (!rnd_req[i] && !bus.grant[i] && $urandom_range(3) == 0) rnd_req[i] = 1'b1;
        rnd_dur[DW*i +: DW] = DW'($urandom_range(4));
      end
      // Operation timeline from ISSUE (k=0): zero duration ends at k=1,
      // otherwise timer runs k=1..d and done follows at k=d+2.
      if (!m_act) begin
        m_st = 1'b0; m_done = '0;
        if (rnd_req != '0) begin
          m_w = rr(m_last, rnd_req);
          m_d = int'(rnd_dur[DW*m_w +: DW]);
          m_act = 1'b1; m_k = 0;
          m_dn = (m_d == 0) ? 1 : m_d + 2;
          m_g = 4'(1) << m_w; m_din = DW'(m_d); m_st = (m_d != 0); m_busy = 1'b1;
        end else begin
          m_g = '0; m_busy = 1'b0;
        end
      end else begin
        m_k++; m_st = 1'b0;
        if (m_k == m_dn) m_done = m_g;
        else if (m_k == m_dn + 1) begin
          m_act = 1'b0; m_last = m_w; m_g = '0; m_done = '0; m_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int starts, done_at, busy_last, n, zc;
    logic [3:0] done_v, prev_g;
    logic [3:0] order [5];
    bit stable;

    tv[0] = '{4'b0001, {8'd9, 8'd9, 8'd9, 8'd3}, 4'b0001, 8'd3, 1'b1};
    tv[1] = '{4'b1010, {8'd7, 8'd0, 8'd5, 8'd0}, 4'b0010, 8'd5, 1'b1};
    tv[2] = '{4'b1000, {8'd2, 8'd1, 8'd1, 8'd1}, 4'b1000, 8'd2, 1'b1};
    tv[3] = '{4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, 4'b0001, 8'd1, 1'b1};
    tv[4] = '{4'b0110, {8'd0, 8'd0, 8'd6, 8'd0}, 4'b0010, 8'd6, 1'b1};
    tv[5] = '{4'b1100, {8'd1, 8'd0, 8'd1, 8'd1}, 4'b0100, 8'd0, 1'b0};

    // First arbitration after reset always starts searching at requester 0.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      @(negedge clk); man_req = tv[v].req; man_dur = tv[v].dur;
      @(negedge clk);
      chk("tv_grant", bus.grant, tv[v].g);
      chk("tv_din", bus.wt_din, tv[v].din);
      chk("tv_start", bus.wt_start, tv[v].st);
      watch(40, -1, starts, done_at, done_v, busy_last, stable);
      chk("tv_done", done_v, tv[v].g);
      chk("tv_stable", stable, 1);
    end

    // Single request with 3-cycle timer.
    do_reset();
    @(negedge clk); man_req = 4'b0001; man_dur = {8'd0, 8'd0, 8'd0, 8'd3};
    @(negedge clk);
    chk("single_grant", bus.grant, 4'b0001);
    chk("single_din", bus.wt_din, 3);
    watch(30, -1, starts, done_at, done_v, busy_last, stable);
    chk("single_starts", starts, 1);
    chk("single_done", done_v, 4'b0001);
    chk("single_done_lat", done_at, busy_last + 2);
    man_req = '0;
    @(negedge clk);
    chk("single_idle_grant", bus.grant, 0);
    chk("single_idle_busy", bus.busy, 0);

    // Round robin with everyone requesting, one idle cycle between grants.
    do_reset();
    @(negedge clk); man_req = 4'b1111; man_dur = {4{8'd1}};
    n = 0; zc = 0; prev_g = '0;
    for (int c = 0; c < 80 && n < 5; c++) begin
      @(negedge clk);
      if (bus.grant != '0 && prev_g == '0) begin
        order[n] = bus.grant;
        if (n > 0) chk("rr_gap", zc, 1);
        n++;
      end
      zc = (bus.grant == '0) ? zc + 1 : 0;
      prev_g = bus.grant;
    end
    chk("rr_count", n, 5);
    chk("rr_g0", order[0], 4'b0001);
    chk("rr_g1", order[1], 4'b0010);
    chk("rr_g2", order[2], 4'b0100);
    chk("rr_g3", order[3], 4'b1000);
    chk("rr_g4", order[4], 4'b0001);

    // Zero duration: no start, done in the cycle right after ISSUE.
    do_reset();
    @(negedge clk); man_req = 4'b0100; man_dur = {8'd5, 8'd0, 8'd5, 8'd5};
    @(negedge clk);
    chk("zero_grant", bus.grant, 4'b0100);
    watch(10, -1, starts, done_at, done_v, busy_last, stable);
    chk("zero_starts", starts, 0);
    chk("zero_done_at", done_at, 1);
    chk("zero_done", done_v, 4'b0100);

    // Lost start: timer never goes busy, two ARM cycles then done.
    do_reset();
    tmr_dead = 1'b1;
    @(negedge clk); man_req = 4'b0010; man_dur = {8'd0, 8'd0, 8'd5, 8'd0};
    @(negedge clk);
    chk("wd_grant", bus.grant, 4'b0010);
    watch(20, -1, starts, done_at, done_v, busy_last, stable);
    chk("wd_starts", starts, 1);
    chk("wd_done_at", done_at, 3);
    chk("wd_done", done_v, 4'b0010);
    chk("wd_stable", stable, 1);

    // Reset during RUN aborts without done; priority restarts at requester 0.
    do_reset();
    tmr_stuck = 1'b1;
    @(negedge clk); man_req = 4'b0001; man_dur = {4{8'd2}};
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rrun_busy", bus.busy, 1);
    chk("rrun_grant", bus.grant, 4'b0001);
    rst = 1'b0;
    #1;
    chk("rrun_abort_grant", bus.grant, 0);
    chk("rrun_abort_busy", bus.busy, 0);
    chk("rrun_abort_done", bus.done, 0);
    @(negedge clk);
    chk("rrun_hold_done", bus.done, 0);
    tmr_stuck = 1'b0; man_req = 4'b1010; rst = 1'b1;
    @(negedge clk);
    chk("rrun_first_grant", bus.grant, 4'b0010);
    watch(30, -1, starts, done_at, done_v, busy_last, stable);
    chk("rrun_done", done_v, 4'b0010);

    // Request dropped mid-operation still completes with the latched duration.
    do_reset();
    @(negedge clk); man_req = 4'b1000; man_dur = {8'd4, 8'd0, 8'd0, 8'd0};
    @(negedge clk);
    chk("drop_din0", bus.wt_din, 4);
    watch(30, 3, starts, done_at, done_v, busy_last, stable);
    chk("drop_done", done_v, 4'b1000);
    chk("drop_done_at", done_at, 6);
    chk("drop_din_done", bus.wt_din, 4);
    @(negedge clk);
    chk("drop_din_idle", bus.wt_din, 4);
    chk("drop_idle_grant", bus.grant, 0);

    // Randomized run against the model.
    do_reset();
    @(negedge clk);
    m_g = '0; m_done = '0; m_din = '0; m_st = 1'b0; m_busy = 1'b0;
    m_act = 1'b0; m_last = 3; rnd_req = '0; rnd_dur = '0;
    #1 rnd_on = 1'b1;
    repeat (3000) @(negedge clk);
    #1 rnd_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
